// File: rtl/ram_sdp_param.sv
// rtl/ram_sdp_param.sv - parametrised simple dual-port RAM with byte enables and clear sweep
// One write port, one read port, 1- or 2-cycle read latency, hardware zero-fill sequencer.

module ram_sdp_param #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    output logic                      busy,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]     write_addr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      re,
    input  logic [ADDR_WIDTH-1:0]     read_addr,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      data_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  idle;
    logic                  wr_en;
    logic                  rd_en;
    logic                  wr_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_v1_q;
    logic [DATA_WIDTH-1:0] rd_d1_q;

    // A clear sampled in IDLE pre-empts any write/read on the same edge.
    assign idle   = (state_q == ST_IDLE);
    assign wr_en  = idle && we && !clear;
    assign rd_en  = idle && re && !clear;
    assign wr_hit = wr_en && (write_addr == read_addr);
    assign busy   = (state_q == ST_CLEAR);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Array has no reset; only the sweep or explicit writes change its contents.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    mem_q[write_addr][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem_q[read_addr];
        if ((RDW_MODE != 0) && wr_hit) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    rd_word[8*i +: 8] = data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q <= 1'b0;
            rd_d1_q <= '0;
        end else begin
            rd_v1_q <= rd_en;
            if (rd_en) begin
                rd_d1_q <= rd_word;
            end
        end
    end

    // Second stage keeps running during a sweep so in-flight reads still complete.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_v2_q;
            logic [DATA_WIDTH-1:0] rd_d2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_v2_q <= 1'b0;
                    rd_d2_q <= '0;
                end else begin
                    rd_v2_q <= rd_v1_q;
                    if (rd_v1_q) begin
                        rd_d2_q <= rd_d1_q;
                    end
                end
            end

            assign data_out   = rd_d2_q;
            assign data_valid = rd_v2_q;
        end else begin : g_lat1
            assign data_out   = rd_d1_q;
            assign data_valid = rd_v1_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_param.sv
// tb/tb_ram_sdp_param.sv - directed bench for ram_sdp_param
// Three instances share stimulus: 32b/RL1/old-data, 32b/RL2/new-data, 8b/16-deep without auto-clear.

module tb_ram_sdp_param;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  write_addr;
    logic [31:0] data_in;
    logic        re;
    logic [5:0]  read_addr;

    logic        busy_a, busy_b, busy_c;
    logic [31:0] dout_a, dout_b;
    logic [7:0]  dout_c;
    logic        dv_a, dv_b, dv_c;

    int total = 0;
    int bad   = 0;
    int na, nb, dvs, va, vb;

    ram_sdp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(1), .RDW_MODE(0),
                    .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_a), .we(we), .be(be),
        .write_addr(write_addr), .data_in(data_in), .re(re), .read_addr(read_addr),
        .data_out(dout_a), .data_valid(dv_a));

    ram_sdp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LATENCY(2), .RDW_MODE(1),
                    .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_b), .we(we), .be(be),
        .write_addr(write_addr), .data_in(data_in), .re(re), .read_addr(read_addr),
        .data_out(dout_b), .data_valid(dv_b));

    ram_sdp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_MODE(0),
                    .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_c), .we(we), .be(be[0:0]),
        .write_addr(write_addr[3:0]), .data_in(data_in[7:0]), .re(re),
        .read_addr(read_addr[3:0]), .data_out(dout_c), .data_valid(dv_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts samples with busy high starting at the current sample; optional stray clear pulse.
    task automatic count_busy(input bit pulse, output int ca, output int cb, output int cv);
        ca = 0;
        cb = 0;
        cv = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) ca++;
            if (busy_b) cb++;
            clear = pulse && (k == 10);
            cyc();
            if (dv_a) cv++;
            if (dv_b) cv++;
        end
        clear = 1'b0;
    endtask

    task automatic readback_all(output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 64; i++) begin
            re        = 1'b1;
            read_addr = 6'(i);
            cyc();
            if (dv_a && dout_a === 32'h0) ca++;
            if (dv_b && dout_b === 32'h0) cb++;
        end
        re = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (dv_a) ca++;
            if (dv_b) cb++;
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; we = 1'b0; be = 4'h0; write_addr = '0;
        data_in = '0; re = 1'b0; read_addr = '0;
        cyc();
        cyc();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        chk("rst_busy_c", 32'(busy_c), 32'd0);
        chk("rst_dout_a", dout_a, 32'h0);
        chk("rst_dv_a",   32'(dv_a), 32'd0);
        chk("rst_dout_b", dout_b, 32'h0);
        chk("rst_dv_b",   32'(dv_b), 32'd0);
        chk("rst_dout_c", 32'(dout_c), 32'h0);

        // Write/read held during the power-up sweep: a/b ignore it, c is idle and honours it.
        we = 1'b1; be = 4'h1; write_addr = 6'd9; data_in = 32'h5A;
        re = 1'b1; read_addr = 6'd9;
        rst_n = 1'b1;
        count_busy(1'b0, na, nb, dvs);
        we = 1'b0; re = 1'b0;
        chk("init_busy_a", 32'(na), 32'd64);
        chk("init_busy_b", 32'(nb), 32'd64);
        chk("init_no_dv",  32'(dvs), 32'd0);
        chk("c_dout",      32'(dout_c), 32'h5A);
        chk("c_dv",        32'(dv_c), 32'd1);
        readback_all(va, vb);
        chk("init_rb_a", 32'(va), 32'd64);
        chk("init_rb_b", 32'(vb), 32'd64);

        // Byte-enable merge and be=0 no-op.
        we = 1'b1; be = 4'hF; write_addr = 6'd5; data_in = 32'hAABBCCDD;
        cyc();
        be = 4'b0101; data_in = 32'h11223344;
        cyc();
        be = 4'h0; data_in = 32'hFFFFFFFF;
        cyc();
        we = 1'b0; re = 1'b1; read_addr = 6'd5;
        cyc();
        re = 1'b0;
        chk("be_dout_a", dout_a, 32'hAA22CC44);
        chk("be_dv_a",   32'(dv_a), 32'd1);
        cyc();
        chk("be_dv_a_off", 32'(dv_a), 32'd0);
        chk("be_hold_a",   dout_a, 32'hAA22CC44);
        chk("be_dout_b",   dout_b, 32'hAA22CC44);
        chk("be_dv_b",     32'(dv_b), 32'd1);
        cyc();
        chk("be_dv_b_off", 32'(dv_b), 32'd0);
        chk("be_hold_b",   dout_b, 32'hAA22CC44);

        // Back-to-back reads, latency 1 vs 2.
        we = 1'b1; be = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            write_addr = 6'(i);
            data_in    = 32'(i);
            cyc();
        end
        we = 1'b0; re = 1'b1; read_addr = 6'd1;
        cyc();
        chk("lat_b_n0_dv", 32'(dv_b), 32'd0);
        chk("lat_a_n0",    dout_a, 32'h1);
        read_addr = 6'd2;
        cyc();
        chk("lat_b_n1_dv", 32'(dv_b), 32'd1);
        chk("lat_b_n1",    dout_b, 32'h1);
        chk("lat_a_n1",    dout_a, 32'h2);
        read_addr = 6'd3;
        cyc();
        chk("lat_b_n2_dv", 32'(dv_b), 32'd1);
        chk("lat_b_n2",    dout_b, 32'h2);
        re = 1'b0;
        cyc();
        chk("lat_b_n3_dv", 32'(dv_b), 32'd1);
        chk("lat_b_n3",    dout_b, 32'h3);
        chk("lat_a_n3_dv", 32'(dv_a), 32'd0);
        cyc();
        chk("lat_b_n4_dv", 32'(dv_b), 32'd0);

        // Same-address read during write.
        we = 1'b1; be = 4'hF; write_addr = 6'd7; data_in = 32'h10;
        cyc();
        data_in = 32'h20; re = 1'b1; read_addr = 6'd7;
        cyc();
        we = 1'b0; re = 1'b0;
        chk("rdw_old_a", dout_a, 32'h10);
        cyc();
        chk("rdw_new_b", dout_b, 32'h20);
        we = 1'b1; be = 4'b0010; data_in = 32'h00003300; re = 1'b1;
        cyc();
        we = 1'b0; re = 1'b0;
        chk("rdw_merge_a", dout_a, 32'h20);
        cyc();
        chk("rdw_merge_b", dout_b, 32'h3320);
        re = 1'b1;
        cyc();
        re = 1'b0;
        chk("merge_stored_a", dout_a, 32'h3320);
        cyc();

        // Clear wins over same-edge write/read; an earlier read still completes on b.
        re = 1'b1; read_addr = 6'd2;
        cyc();
        chk("pre_clr_a", dout_a, 32'h2);
        clear = 1'b1; we = 1'b1; be = 4'hF; write_addr = 6'd3; data_in = 32'h55;
        read_addr = 6'd3;
        cyc();
        clear = 1'b0; we = 1'b0; re = 1'b0;
        chk("clr_busy_a",   32'(busy_a), 32'd1);
        chk("clr_drop_dva", 32'(dv_a), 32'd0);
        chk("inflight_dvb", 32'(dv_b), 32'd1);
        chk("inflight_b",   dout_b, 32'h2);
        count_busy(1'b1, na, nb, dvs);
        chk("clr_busy_cnt_a", 32'(na), 32'd64);
        chk("clr_busy_cnt_b", 32'(nb), 32'd64);
        chk("clr_no_dv",      32'(dvs), 32'd0);
        re = 1'b1; read_addr = 6'd3;
        cyc();
        re = 1'b0;
        chk("clr_a3_a",  dout_a, 32'h0);
        chk("clr_a3_dv", 32'(dv_a), 32'd1);
        cyc();
        chk("clr_a3_b",  dout_b, 32'h0);

        // Reset during a sweep at address 30.
        we = 1'b1; be = 4'hF; write_addr = 6'd40; data_in = 32'hDEADBEEF;
        cyc();
        write_addr = 6'd50; data_in = 32'h12345678;
        cyc();
        we = 1'b0; re = 1'b1; read_addr = 6'd50;
        cyc();
        re = 1'b0;
        cyc();
        chk("pre_rst_a", dout_a, 32'h12345678);
        chk("pre_rst_b", dout_b, 32'h12345678);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (30) cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout_a", dout_a, 32'h0);
        chk("mid_rst_dout_b", dout_b, 32'h0);
        chk("mid_rst_dv_a",   32'(dv_a), 32'd0);
        chk("mid_rst_busy_a", 32'(busy_a), 32'd1);
        chk("mid_rst_busy_c", 32'(busy_c), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        count_busy(1'b0, na, nb, dvs);
        chk("rst2_busy_a", 32'(na), 32'd64);
        chk("rst2_busy_b", 32'(nb), 32'd64);
        readback_all(va, vb);
        chk("rst2_rb_a", 32'(va), 32'd64);
        chk("rst2_rb_b", 32'(vb), 32'd64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
